qpsk_mapper: RTL and testbench
==============================

// Module: qpsk_mapper
// PURPOSE
//  Downstream neighbour of the rate-limited chip FIFO in the modulator. Pairs the 1-bit
//  spread-chip stream into QPSK symbols: first chip is I, second chip is Q. Maps each
//  symbol to signed +/-AMPLITUDE samples. Zero-stuffs by UPSAMPLE and drives packed
//  {Q,I} samples over an AXI-Stream-style valid/ready link into the interpolating FIR.
// PARAMETERS
//  SAMPLE_WIDTH  16        width of each signed I or Q sample
//  AMPLITUDE     11585     magnitude for a chip; must satisfy 0 < AMPLITUDE < 2**(SAMPLE_WIDTH-1)
//  UPSAMPLE      4         output samples per symbol: 1 symbol + UPSAMPLE-1 zeros; must be >=1
//  FIFO_DEPTH    4         symbol buffer entries; must be a power of 2 and >=2
// PORTS
//  i_clk          in   1               clock
//  i_reset        in   1               asynchronous reset, active-low
//  i_data         in   1               chip value (0 or 1)
//  i_valid        in   1               chip strobe; there is no ready, so upstream never stalls
//  o_tdata        out  2*SAMPLE_WIDTH  {Q[SW-1:0], I[SW-1:0]}, two's complement
//  o_tvalid       out  1               output sample valid
//  i_tready       in   1               FIR accepts the sample
//  o_overflow     out  1               sticky flag: a symbol was dropped because the FIFO was full
//  o_level        out  $clog2(FIFO_DEPTH)+1  current symbol FIFO occupancy
// BEHAVIOUR
//  Reset: i_reset=0 asynchronously clears all state.
//   - o_tdata=0, o_tvalid=0, o_overflow=0, o_level=0.
//   - Pair phase returns to I; FIFO is emptied; emitter goes to IDLE.
//  Pairing: a 1-bit phase register toggles on each i_valid.
//   - Phase I: store the chip.
//   - Phase Q: form the symbol {Q=i_data, I=stored} and push it on the same edge.
//   - Chips with i_valid=0 are ignored.
//  Mapping, applied at emitter load: chip 0 -> +AMPLITUDE, chip 1 -> -AMPLITUDE.
//   - Negation is computed at SAMPLE_WIDTH bits; no saturation is needed given the AMPLITUDE bound.
//  Overflow: a push while level==FIFO_DEPTH with no pop on that edge drops the new symbol.
//   - The pair phase still toggles, so I/Q alignment is kept.
//   - o_overflow sets on the next edge and stays set until reset.
//   - Push and pop on the same edge at full: both proceed and the level is unchanged.
//  Emitter FSM (states IDLE, SYM, ZERO; zero counter width $clog2(UPSAMPLE)+1):
//   - IDLE: if level>0, pop, load the mapped sample into o_tdata, set o_tvalid=1, go to SYM.
//   - SYM: hold o_tdata until i_tready. On handshake:
//     - UPSAMPLE>1: load o_tdata=0, cnt=UPSAMPLE-2, go to ZERO.
//     - UPSAMPLE==1: pop the next symbol if available and stay in SYM; else o_tvalid=0, go to IDLE.
//   - ZERO: o_tvalid=1, o_tdata=0. On handshake:
//     - cnt>0: cnt--.
//     - cnt==0: back-to-back load of the next symbol (go to SYM) if level>0; else o_tvalid=0, go to IDLE.
//  AXIS rules:
//   - o_tdata and o_tvalid never change while o_tvalid=1 and i_tready=0.
//   - o_tvalid never depends combinationally on i_tready.
//   - All outputs are registered.
//  Latency: with the emitter in IDLE and the FIFO empty, o_tvalid rises 2 edges after the edge
//   sampling the Q chip (push edge +1 pop/load edge).
//  Throughput: 1 sample/clk when i_tready=1. Zero samples are emitted even if the FIFO is empty.
//  Reset mid-operation: a held sample is abandoned (o_tvalid drops immediately) and a half pair is discarded.
// STRUCTURE
//  modulator_pkg:
//   - typedef enum logic [1:0] {EMIT_IDLE, EMIT_SYM, EMIT_ZERO} emit_state_t;
//   - typedef struct packed {logic q; logic i;} qpsk_sym_t;
//   - function map_chip(bit, amp) -> signed sample.
//  One sub-module, sym_fifo: synchronous FIFO of qpsk_sym_t with push/pop/level,
//   async active-low reset, and same-cycle push+pop at full or empty.
//  Pairing, mapping and the emitter FSM live in qpsk_mapper.
// TESTING (SAMPLE_WIDTH=16, AMPLITUDE=11585, UPSAMPLE=4, FIFO_DEPTH=4 unless stated)
//  1 Chips 0,1 with i_tready=1:
//    -> o_tvalid rises 2 clk after the Q chip.
//    -> samples {Q=-11585 (0xD2BF), I=+11585 (0x2D41)}, then 0,0,0; then o_tvalid=0.
//  2 Chips 1,1,0,0 back-to-back, i_tready=1:
//    -> 8 consecutive valid cycles: {0xD2BF,0xD2BF},0,0,0,{0x2D41,0x2D41},0,0,0.
//  3 Backpressure: i_tready=0 for 5 clk while a symbol sample is presented
//    -> o_tdata and o_tvalid are stable for all 5 clk; the sequence resumes on release.
//  4 Overflow: i_tready=0, push 5 symbols (10 chips)
//    -> o_level saturates at 4; o_overflow=1 after the 5th push.
//    -> on release, the first 4 symbols emerge in order and the 5th is absent.
//  5 Reset asserted while in ZERO with o_level=2 and one I chip pending
//    -> all outputs 0 asynchronously.
//    -> after release, chips 0,0 yield {0x2D41,0x2D41} first.
//  6 UPSAMPLE=1 and i_tready=1, chips pushed every clk
//    -> one symbol sample per 2 clk, no zeros, o_overflow stays 0.

Source files
------------

// File: rtl/modulator_pkg.sv
// rtl/modulator_pkg.sv - shared types and chip mapping for the QPSK modulator path
package modulator_pkg;

    typedef enum logic [1:0] {EMIT_IDLE, EMIT_SYM, EMIT_ZERO} emit_state_t;

    typedef struct packed {
        logic q;
        logic i;
    } qpsk_sym_t;

    // Chip 0 maps to +amp and chip 1 to -amp; callers truncate to their sample width.
    function automatic logic signed [31:0] map_chip(input logic chip, input logic signed [31:0] amp);
        return chip ? -amp : amp;
    endfunction

endpackage

// File: rtl/qpsk_mapper_sym_fifo.sv
// rtl/qpsk_mapper_sym_fifo.sv - small synchronous FIFO of QPSK symbols with drop indication
module sym_fifo
    import modulator_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  qpsk_sym_t                  push_data,
    input  logic                       pop,
    output qpsk_sym_t                  pop_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    qpsk_sym_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            pop_ok;
    logic            push_ok;

    // A pop always frees a slot, so a push at full is only dropped when no pop happens on that edge.
    assign pop_ok   = pop && (level != '0);
    assign push_ok  = push && ((level != LW'(DEPTH)) || pop_ok);
    assign drop     = push && !push_ok;
    assign pop_data = mem[rd_ptr];

    // Storage needs no reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/qpsk_mapper.sv
// rtl/qpsk_mapper.sv - pairs chips into QPSK symbols, maps and zero-stuffs them onto a stream
module qpsk_mapper
    import modulator_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int AMPLITUDE    = 11585,
    parameter int UPSAMPLE     = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_data,
    input  logic                          i_valid,
    output logic [2*SAMPLE_WIDTH-1:0]     o_tdata,
    output logic                          o_tvalid,
    input  logic                          i_tready,
    output logic                          o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    localparam int CW = $clog2(UPSAMPLE) + 1;

    logic                        phase;
    logic                        i_chip;
    logic                        push;
    qpsk_sym_t                   push_sym;
    logic                        pop;
    qpsk_sym_t                   head;
    logic                        drop;
    logic [SAMPLE_WIDTH-1:0]     map_i;
    logic [SAMPLE_WIDTH-1:0]     map_q;
    logic [2*SAMPLE_WIDTH-1:0]   mapped;
    logic                        handshake;

    emit_state_t                 state;
    emit_state_t                 state_n;
    logic [2*SAMPLE_WIDTH-1:0]   tdata_n;
    logic                        tvalid_n;
    logic [CW-1:0]               cnt;
    logic [CW-1:0]               cnt_n;

    // Phase toggles on every chip strobe even when the symbol is dropped, keeping I/Q alignment.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            phase  <= 1'b0;
            i_chip <= 1'b0;
        end else if (i_valid) begin
            phase <= ~phase;
            if (!phase) begin
                i_chip <= i_data;
            end
        end
    end

    assign push       = i_valid && phase;
    assign push_sym.q = i_data;
    assign push_sym.i = i_chip;

    sym_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_sym_fifo (
        .clk       (i_clk),
        .rst_n     (i_reset),
        .push      (push),
        .push_data (push_sym),
        .pop       (pop),
        .pop_data  (head),
        .level     (o_level),
        .drop      (drop)
    );

    // Sticky record that at least one symbol was lost to a full FIFO.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_overflow <= 1'b0;
        end else if (drop) begin
            o_overflow <= 1'b1;
        end
    end

    assign map_i     = SAMPLE_WIDTH'(map_chip(head.i, AMPLITUDE));
    assign map_q     = SAMPLE_WIDTH'(map_chip(head.q, AMPLITUDE));
    assign mapped    = {map_q, map_i};
    assign handshake = o_tvalid && i_tready;

    // Emitter state and registered stream outputs.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state    <= EMIT_IDLE;
            o_tdata  <= '0;
            o_tvalid <= 1'b0;
            cnt      <= '0;
        end else begin
            state    <= state_n;
            o_tdata  <= tdata_n;
            o_tvalid <= tvalid_n;
            cnt      <= cnt_n;
        end
    end

    // Emitter next-state: symbol sample, then UPSAMPLE-1 zeros, chaining symbols without bubbles.
    always_comb begin
        state_n  = state;
        tdata_n  = o_tdata;
        tvalid_n = o_tvalid;
        cnt_n    = cnt;
        pop      = 1'b0;
        case (state)
            EMIT_IDLE: begin
                if (o_level != '0) begin
                    pop      = 1'b1;
                    tdata_n  = mapped;
                    tvalid_n = 1'b1;
                    state_n  = EMIT_SYM;
                end
            end
            EMIT_SYM: begin
                if (handshake) begin
                    if (UPSAMPLE > 1) begin
                        tdata_n = '0;
                        cnt_n   = CW'(UPSAMPLE - 2);
                        state_n = EMIT_ZERO;
                    end else if (o_level != '0) begin
                        pop     = 1'b1;
                        tdata_n = mapped;
                    end else begin
                        tdata_n  = '0;
                        tvalid_n = 1'b0;
                        state_n  = EMIT_IDLE;
                    end
                end
            end
            EMIT_ZERO: begin
                if (handshake) begin
                    if (cnt != '0) begin
                        cnt_n = cnt - CW'(1);
                    end else if (o_level != '0) begin
                        pop     = 1'b1;
                        tdata_n = mapped;
                        state_n = EMIT_SYM;
                    end else begin
                        tvalid_n = 1'b0;
                        state_n  = EMIT_IDLE;
                    end
                end
            end
            default: begin
                tdata_n  = '0;
                tvalid_n = 1'b0;
                state_n  = EMIT_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_qpsk_mapper.sv
// tb/tb_qpsk_mapper.sv - randomized and directed self-checking bench for qpsk_mapper
module tb_qpsk_mapper;

    localparam int AMP = 11585;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        d, v, tready;
    logic [31:0] tdata;
    logic        tvalid, ovf;
    logic [2:0]  level;
    logic        d1, v1, tready1;
    logic [31:0] tdata1;
    logic        tvalid1, ovf1;
    logic [2:0]  level1;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp1[$];
    bit          phase0, held0;
    int          run, max_run, n1, cyc;
    bit          rand_ready;

    always #5 clk = ~clk;

    qpsk_mapper #(.SAMPLE_WIDTH(16), .AMPLITUDE(AMP), .UPSAMPLE(4), .FIFO_DEPTH(4)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_data(d), .i_valid(v),
        .o_tdata(tdata), .o_tvalid(tvalid), .i_tready(tready),
        .o_overflow(ovf), .o_level(level)
    );

    qpsk_mapper #(.SAMPLE_WIDTH(16), .AMPLITUDE(AMP), .UPSAMPLE(1), .FIFO_DEPTH(4)) dut1 (
        .i_clk(clk), .i_reset(rst_n), .i_data(d1), .i_valid(v1),
        .o_tdata(tdata1), .o_tvalid(tvalid1), .i_tready(tready1),
        .o_overflow(ovf1), .o_level(level1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sym_sample(input bit q, input bit i);
        logic [15:0] pos, neg;
        pos = 16'(AMP);
        neg = 16'(65536 - AMP);
        return {q ? neg : pos, i ? neg : pos};
    endfunction

    task automatic cycle();
        logic [31:0] e;
        if (tvalid && tready) begin
            if (exp_q.size() == 0) check("unexpected_sample", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("sample", tdata, e);
            end
        end
        if (tvalid1 && tready1) begin
            n1++;
            if (exp1.size() == 0) check("unexpected_sample_us1", 1, 0);
            else begin
                e = exp1.pop_front();
                check("sample_us1", tdata1, e);
            end
        end
        if (tvalid) run++; else run = 0;
        if (run > max_run) max_run = run;
        @(posedge clk);
        #1;
        cyc++;
        if (rand_ready) tready = (cyc % 2 == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    endtask

    task automatic chip(input bit b, input bit keep = 1'b1);
        if (phase0) begin
            if (keep) begin
                exp_q.push_back(sym_sample(b, held0));
                repeat (3) exp_q.push_back(32'h0);
            end
        end else begin
            held0 = b;
        end
        phase0 = !phase0;
        v = 1'b1;
        d = b;
        cycle();
        v = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || tvalid) && n < 300) begin
            cycle();
            n++;
        end
        check({tag, "_drained"}, {31'd0, (exp_q.size() == 0) && !tvalid}, 1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!tvalid && n < 20) begin
            cycle();
            n++;
        end
        check({tag, "_valid_seen"}, tvalid, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit b, bq;
        rst_n = 1'b0; d = 0; v = 0; tready = 0; d1 = 0; v1 = 0; tready1 = 0;
        rand_ready = 0; run = 0; max_run = 0; n1 = 0; cyc = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tdata", tdata, 0);
        check("reset_tvalid", tvalid, 0);
        check("reset_overflow", ovf, 0);
        check("reset_level", level, 0);
        rst_n = 1'b1;
        cycle();

        // Test 1: chips 0,1 -> latency and sample sequence
        tready = 1'b1;
        chip(0);
        chip(1);
        check("lat_after_q_edge", tvalid, 0);
        cycle();
        check("lat_two_edges", tvalid, 1);
        check("first_sample", tdata, 32'hD2BF2D41);
        drain("t1");

        // Test 2: 1,1,0,0 back-to-back -> 8 consecutive valid cycles
        max_run = 0;
        chip(1); chip(1); chip(0); chip(0);
        drain("t2");
        check("t2_run_length", max_run, 8);

        // Test 3: backpressure holds the presented sample
        tready = 1'b0;
        chip(0); chip(0);
        wait_valid("t3");
        for (int k = 0; k < 5; k++) begin
            check("t3_hold", {tvalid, tdata}, {1'b1, 32'h2D412D41});
            cycle();
        end
        tready = 1'b1;
        drain("t3");

        // Test 4: overflow with emitter already holding one symbol
        tready = 1'b0;
        chip(1); chip(0);
        wait_valid("t4");
        for (int s = 0; s < 5; s++) begin
            b = 1'($urandom_range(0, 1));
            bq = 1'($urandom_range(0, 1));
            chip(b);
            chip(bq, s != 4);
            check("t4_level", level, (s + 1 < 4) ? s + 1 : 4);
        end
        cycle();
        check("t4_overflow", ovf, 1);
        check("t4_level_full", level, 4);
        tready = 1'b1;
        drain("t4");
        check("t4_overflow_sticky", ovf, 1);

        // Test 5: asynchronous reset while in ZERO with level 2 and a pending I chip
        for (int k = 0; k < 6; k++) chip(1'($urandom_range(0, 1)));
        tready = 1'b0;
        chip(1);
        check("t5_pre_level", level, 2);
        check("t5_pre_zero", {tvalid, tdata}, {1'b1, 32'h0});
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_async_tdata", tdata, 0);
        check("t5_async_tvalid", tvalid, 0);
        check("t5_async_overflow", ovf, 0);
        check("t5_async_level", level, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        phase0 = 0;
        tready = 1'b1;
        chip(0); chip(0);
        cycle();
        check("t5_first_after_reset", {tvalid, tdata}, {1'b1, 32'h2D412D41});
        drain("t5");

        // Random stream with bounded backpressure; symbol rate stays below drain rate
        rand_ready = 1'b1;
        for (int s = 0; s < 30; s++) begin
            chip(1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) cycle();
            chip(1'($urandom_range(0, 1)));
            repeat ($urandom_range(10, 14)) cycle();
        end
        drain("rand");
        rand_ready = 1'b0;
        tready = 1'b1;
        check("rand_no_overflow", ovf, 0);

        // Test 6: UPSAMPLE=1, chips every clock
        tready1 = 1'b1;
        n1 = 0;
        for (int k = 0; k < 40; k++) begin
            d1 = 1'($urandom_range(0, 1));
            v1 = 1'b1;
            if (k % 2 == 1) exp1.push_back(sym_sample(d1, held0));
            else held0 = d1;
            cycle();
        end
        v1 = 1'b0;
        for (int k = 0; k < 20 && (exp1.size() != 0 || tvalid1); k++) cycle();
        check("us1_count", n1, 20);
        check("us1_queue_empty", exp1.size(), 0);
        check("us1_no_overflow", ovf1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
